// File: rtl/aes_pkg.sv
// Shared AES byte-substitution definitions: FIPS-197 S-box tables, lookup helper,
// state type, FSM encodings and the legal lane-count check.
package aes_pkg;

  typedef logic [127:0] aes_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] b, input logic inv);
    if (inv) begin
      return INV_SBOX[b];
    end else begin
      return SBOX[b];
    end
  endfunction

  function automatic bit lanes_legal(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8) || (lanes == 16);
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// Single-byte combinational S-box lookup; the inverse table and its select input
// exist only when AES_INV_SBOX_EN is defined.
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
`ifdef AES_INV_SBOX_EN
  input  logic       inv_i,
`endif
  output logic [7:0] data_o
);

`ifdef AES_INV_SBOX_EN
  assign data_o = sbox_lookup(data_i, inv_i);
`else
  assign data_o = SBOX[data_i];
`endif

endmodule

// File: rtl/aes_sub_bytes_iter.sv
// Iterative AES SubBytes engine: LANES lookups per cycle, 16/LANES busy cycles per block.
// Optional macro AES_INV_SBOX_EN adds the in_inv port and per-block InvSubBytes mode.
module aes_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef AES_INV_SBOX_EN
  input  logic         in_inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int STEPS = 16 / LANES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (!lanes_legal(LANES)) begin : g_lanes_check
    $error("aes_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  aes_state_t    data_q, data_d;
  logic          load_s;
  logic [3:0]    idx_s      [LANES];
  logic [7:0]    lane_out_s [LANES];
`ifdef AES_INV_SBOX_EN
  logic          mode_q;
`endif

  // Lane l works on byte k*LANES+l of the working register during step k.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign idx_s[l] = 4'(int'(cnt_q) * LANES + l);
    aes_sbox_lane u_lane (
      .data_i (data_q[{idx_s[l], 3'b000} +: 8]),
`ifdef AES_INV_SBOX_EN
      .inv_i  (mode_q),
`endif
      .data_o (lane_out_s[l])
    );
  end

  // Next-state, counter and working-register update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    load_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          load_s  = 1'b1;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          data_d[{idx_s[l], 3'b000} +: 8] = lane_out_s[l];
        end
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready && in_valid) begin
          load_s  = 1'b1;
          state_d = ST_BUSY;
        end else if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_s) begin
      data_d = in_data;
      cnt_d  = '0;
    end else begin
      data_d = data_d;
    end
  end

  // State, counter and working register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

`ifdef AES_INV_SBOX_EN
  // Substitution direction is fixed for the whole block at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
    end else if (load_s) begin
      mode_q <= in_inv;
    end else begin
      mode_q <= mode_q;
    end
  end
`endif

  // in_ready combinationally follows out_ready in DONE to allow same-edge hand-off.
  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_BUSY);
  assign out_data  = data_q;

endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
// Self-checking bench: one DUT per legal LANES value, checked against S-box tables
// derived from GF(2^8) inversion plus the AES affine map.
module tb_aes_sub_bytes_iter;

  logic         clk;
  logic         rst_n;
  logic         in_valid  [5];
  logic         in_ready  [5];
  logic [127:0] in_data   [5];
  logic         out_valid [5];
  logic         out_ready [5];
  logic [127:0] out_data  [5];
  logic         busy      [5];
`ifdef AES_INV_SBOX_EN
  logic         in_inv    [5];
`endif

  logic [7:0] sbox_ref [256];
  logic [7:0] inv_ref  [256];
  int errors;
  int checks;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    aes_sub_bytes_iter #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
`ifdef AES_INV_SBOX_EN
      .in_inv    (in_inv[g]),
`endif
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_tables();
    logic [7:0] b;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      end
      s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
      sbox_ref[x] = s;
      inv_ref[s]  = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_block(input logic [127:0] d, input logic m);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = m ? inv_ref[d[8*i +: 8]] : sbox_ref[d[8*i +: 8]];
    return r;
  endfunction

  // Present one block, return edges from acceptance (inclusive) to out_valid and the result.
  task automatic send_block(input int idx, input logic [127:0] d, input logic m,
                            output int lat, output logic [127:0] res);
    int n;
    @(negedge clk);
    in_valid[idx] = 1'b1;
    in_data[idx]  = d;
`ifdef AES_INV_SBOX_EN
    in_inv[idx]   = m;
`endif
    n = 0;
    while (!in_ready[idx] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout lane_cfg=%0d in_ready=%b required=1", idx, in_ready[idx]);
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid[idx] = 1'b0;
    while (!out_valid[idx] && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = out_data[idx];
  endtask

  task automatic drain(input int idx);
    @(negedge clk);
    out_ready[idx] = 1'b1;
    @(negedge clk);
    out_ready[idx] = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({in_ready[i], out_valid[i], busy[i], out_data[i]} !== {1'b1, 1'b0, 1'b0, 128'h0}) begin
        errors++;
        $display("FAIL reset_hold cfg=%0d got rdy=%b vld=%b busy=%b data=%h required 1/0/0/0",
                 i, in_ready[i], out_valid[i], busy[i], out_data[i]);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({in_ready[i], out_valid[i], busy[i], out_data[i]} !== {1'b1, 1'b0, 1'b0, 128'h0}) begin
        errors++;
        $display("FAIL reset_release cfg=%0d got rdy=%b vld=%b busy=%b data=%h required 1/0/0/0",
                 i, in_ready[i], out_valid[i], busy[i], out_data[i]);
      end
    end
  endtask

  task automatic test_forward_vector();
    int lat;
    logic [127:0] res;
    send_block(2, 128'h000102030405060708090A0B0C0D0E0F, 1'b0, lat, res);
    checks++;
    if (res !== 128'h637C777BF26B6FC53001672BFED7AB76) begin
      errors++;
      $display("FAIL fwd_vector got=%h required=637c777bf26b6fc53001672bfed7ab76", res);
    end
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL fwd_latency got=%0d required=5", lat);
    end
    drain(2);
  endtask

  task automatic test_boundary();
    int lat;
    logic [127:0] res;
    int cfg [2] = '{0, 4};
    int exp_lat [2] = '{17, 2};
    for (int c = 0; c < 2; c++) begin
      send_block(cfg[c], {16{8'h00}}, 1'b0, lat, res);
      checks++;
      if (res !== {16{8'h63}} || lat !== exp_lat[c]) begin
        errors++;
        $display("FAIL zeros cfg=%0d got=%h lat=%0d required=%h lat=%0d", cfg[c], res, lat, {16{8'h63}}, exp_lat[c]);
      end
      drain(cfg[c]);
      send_block(cfg[c], {16{8'hff}}, 1'b0, lat, res);
      checks++;
      if (res !== {16{8'h16}} || lat !== exp_lat[c]) begin
        errors++;
        $display("FAIL ones cfg=%0d got=%h lat=%0d required=%h lat=%0d", cfg[c], res, lat, {16{8'h16}}, exp_lat[c]);
      end
      drain(cfg[c]);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    int n;
    logic [127:0] res;
    logic [127:0] d1;
    logic [127:0] d2;
    d1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom};
    send_block(2, d1, 1'b0, lat, res);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid[2] !== 1'b1 || out_data[2] !== ref_block(d1, 1'b0) || in_ready[2] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold unstable_cycles=%0d required=0 (data=%h)", bad, out_data[2]);
    end
    in_valid[2]  = 1'b1;
    in_data[2]   = d2;
    out_ready[2] = 1'b1;
    #1;
    checks++;
    if (in_ready[2] !== 1'b1) begin
      errors++;
      $display("FAIL bp_handoff_ready got=%b required=1", in_ready[2]);
    end
    @(negedge clk);
    in_valid[2]  = 1'b0;
    out_ready[2] = 1'b0;
    checks++;
    if (busy[2] !== 1'b1 || out_valid[2] !== 1'b0) begin
      errors++;
      $display("FAIL bp_handoff_busy got busy=%b vld=%b required busy=1 vld=0", busy[2], out_valid[2]);
    end
    n = 0;
    while (!out_valid[2] && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid[2] !== 1'b1 || out_data[2] !== ref_block(d2, 1'b0)) begin
      errors++;
      $display("FAIL bp_second got vld=%b data=%h required vld=1 data=%h", out_valid[2], out_data[2], ref_block(d2, 1'b0));
    end
    drain(2);
  endtask

`ifdef AES_INV_SBOX_EN
  task automatic test_inverse();
    int lat;
    logic [127:0] res;
    logic [127:0] d;
    send_block(2, {16{8'h63}}, 1'b1, lat, res);
    checks++;
    if (res !== 128'h0) begin
      errors++;
      $display("FAIL inv_63 got=%h required=0", res);
    end
    drain(2);
    d = {$urandom, $urandom, $urandom, $urandom};
    d[7:0] = 8'hed;
    send_block(2, d, 1'b1, lat, res);
    checks++;
    if (res[7:0] !== 8'h53 || res !== ref_block(d, 1'b1)) begin
      errors++;
      $display("FAIL inv_ed got=%h required=%h (byte0 53)", res, ref_block(d, 1'b1));
    end
    drain(2);
  endtask
`endif

  task automatic test_reset_mid_busy();
    int lat;
    logic [127:0] res;
    @(negedge clk);
    in_valid[1] = 1'b1;
    in_data[1]  = 128'h0;
    @(posedge clk);
    @(negedge clk);
    in_valid[1] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready[1], out_valid[1], busy[1], out_data[1]} !== {1'b1, 1'b0, 1'b0, 128'h0}) begin
      errors++;
      $display("FAIL reset_mid got rdy=%b vld=%b busy=%b data=%h required 1/0/0/0",
               in_ready[1], out_valid[1], busy[1], out_data[1]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_novalid got=%b required=0", out_valid[1]);
    end
    rst_n = 1'b1;
    send_block(1, 128'h0, 1'b0, lat, res);
    checks++;
    if (res !== {16{8'h63}} || lat !== 9) begin
      errors++;
      $display("FAIL reset_mid_after got=%h lat=%0d required=%h lat=9", res, lat, {16{8'h63}});
    end
    drain(1);
  endtask

  // Random traffic with stalls on both sides; a queue of expected results checks order and count.
  task automatic test_random(input int idx, input int nblk);
    logic [127:0] exp_q [$];
    logic [127:0] d;
    logic [127:0] e;
    logic m;
    int sent;
    int got;
    int cyc;
    bit pres;
    sent = 0;
    got  = 0;
    cyc  = 0;
    pres = 1'b0;
    d    = 128'h0;
    m    = 1'b0;
    while (got < nblk && cyc < nblk * 60) begin
      @(negedge clk);
      cyc++;
      if (!pres && sent < nblk && $urandom_range(3) != 0) begin
        d = {$urandom, $urandom, $urandom, $urandom};
`ifdef AES_INV_SBOX_EN
        m = 1'($urandom_range(1));
`endif
        pres = 1'b1;
      end
      in_valid[idx]  = pres;
      in_data[idx]   = d;
`ifdef AES_INV_SBOX_EN
      in_inv[idx]    = m;
`endif
      out_ready[idx] = ($urandom_range(3) != 0);
      #1;
      if (pres && in_ready[idx]) begin
        exp_q.push_back(ref_block(d, m));
        pres = 1'b0;
        sent++;
      end
      if (out_valid[idx] && out_ready[idx]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra cfg=%0d got=%h required=no output", idx, out_data[idx]);
        end else begin
          e = exp_q.pop_front();
          if (out_data[idx] !== e) begin
            errors++;
            $display("FAIL rand_data cfg=%0d blk=%0d got=%h required=%h", idx, got, out_data[idx], e);
          end
        end
        got++;
      end
    end
    @(negedge clk);
    in_valid[idx]  = 1'b0;
    out_ready[idx] = 1'b0;
    checks++;
    if (got != nblk || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_count cfg=%0d got=%0d pending=%0d required=%0d/0", idx, got, exp_q.size(), nblk);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = 128'h0;
      out_ready[i] = 1'b0;
`ifdef AES_INV_SBOX_EN
      in_inv[i]    = 1'b0;
`endif
    end
    build_tables();
    test_reset();
    test_forward_vector();
    test_boundary();
    test_backpressure();
`ifdef AES_INV_SBOX_EN
    test_inverse();
`endif
    test_reset_mid_busy();
    fork
      test_random(0, 1000);
      test_random(1, 1000);
      test_random(2, 1000);
      test_random(3, 1000);
      test_random(4, 1000);
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_sub_bytes_iter.md
Name: aes_sub_bytes_iter

Overview:
Parametrised, sequential AES SubBytes engine.
- Accepts one 128-bit AES state over a valid/ready handshake.
- Substitutes LANES bytes per clock through LANES S-box lookups, so a block takes 16/LANES cycles.
- Presents the 128-bit result over a second valid/ready handshake.
- Sits between AddRoundKey and ShiftRows in the round datapath. Lets area/throughput be traded by parameter and optionally supports InvSubBytes for the decryption path.

Parameters:
LANES, 4, S-box lookups per cycle; legal values 1, 2, 4, 8, 16 (static assertion otherwise)
STEPS, 16/LANES, derived local constant; BUSY cycles per block

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data valid
in_ready  output  1  block can accept in_data this cycle
in_data  input  128  AES state; byte i = in_data[8i+7:8i], i=0..15
in_inv  input  1  1 = inverse S-box; sampled on acceptance (only with AES_INV_SBOX_EN)
out_valid  output  1  out_data holds a completed block
out_ready  input  1  downstream accepts out_data
out_data  output  128  substituted state, same byte positions as in_data
busy  output  1  high in BUSY state

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset state: state=IDLE, step counter=0, data register=0, mode=0, out_valid=0, out_data=0, busy=0. in_ready=1 while in reset and immediately after.
- FSM: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, load in_data into the 128-bit working register, latch the mode, clear the counter and go to BUSY.
  - BUSY: each cycle, replace bytes [k*LANES .. k*LANES+LANES-1] of the working register with S(byte), or InvS(byte) if the mode is set. k is the counter value. Then increment the counter. When counter==STEPS-1, go to DONE on that edge.
  - DONE: out_valid=1 and out_data = working register.
    - On out_valid&out_ready with in_valid=0, go to IDLE.
    - On out_valid&out_ready with in_valid=1, accept the new block on the same edge and go to BUSY. This is the DONE hand-off.
    - Without out_ready, hold; out_data stays stable.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is a combinational path from out_ready and is documented for integrators.
- Latency: out_valid rises STEPS+1 clock edges after the accepting edge.
  - LANES=4: 4 BUSY cycles, out_valid first visible after 5 edges.
  - LANES=16: 1 BUSY cycle.
- Throughput with out_ready tied high: one block per STEPS+1 cycles.
- in_data and in_inv are ignored outside the acceptance cycle. in_valid in BUSY is neither accepted nor dropped; upstream must hold it.
- Counter width is $clog2(STEPS), minimum 1 bit. The counter wraps to 0 on entry to BUSY and never exceeds STEPS-1.
- Reset asserted mid-operation aborts the block with no output, and all state returns to reset values asynchronously.
- Bytes not yet processed are never exposed, because out_data is only meaningful while out_valid=1.

Optional Feature:
Macro: AES_INV_SBOX_EN.
- Defined: in_inv port exists, the InvS table is instantiated in each lane, and the mode is latched per block.
- Undefined: in_inv port is absent, the mode is constant 0, and only the forward S-box is built (smaller area).
- Forward results are identical in both builds.

Decomposition:
- Shared package aes_pkg:
  - SBOX and INV_SBOX constant arrays [256] of 8-bit, FIPS-197 values.
  - Function sbox_lookup(byte, inv).
  - Typedef aes_state_t (128-bit).
  - The legal LANES check.
- Sub-module aes_sbox_lane: combinational single-byte lookup with fwd/inv select. Instantiate LANES copies; the byte mux per lane is driven by the counter.

Test Plan:
- Forward mapping, LANES=4: in_data=128'h000102030405060708090A0B0C0D0E0F -> out_data=128'h637C777BF26B6FC53001672BFED7AB76; out_valid exactly 5 edges after acceptance.
- All-zero and all-FF blocks, LANES=1 and LANES=16: 00 -> all bytes 63, FF -> all bytes 16. out_valid 17 and 2 edges after acceptance respectively.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. out_data and out_valid must be stable and in_ready=0. Raise out_ready with in_valid=1: the next block is accepted on the same edge and busy=1 next cycle.
- Inverse (AES_INV_SBOX_EN): in_inv=1, all bytes 63 -> all 00; byte ED -> 53. Interleave fwd/inv blocks back-to-back; each block uses its own latched mode.
- Reset mid-BUSY, LANES=2: assert rst_n=0 at step 3. Outputs go to reset values immediately with no out_valid. After release, a fresh 00 block gives all 63.
- Random blocks (1000) against the aes_pkg model for every legal LANES with random valid/ready stalls: no lost, duplicated or reordered blocks.
